// File: rtl/fwd_writeback_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fwd_writeback_pipe
// Purpose  : Destination/result pipeline MA -> WB -> WB2 that feeds the
//            operand-forwarding selector. It carries the rd / RegWEn tags and
//            the data for each stage, builds the EX ALU operands from the
//            hazard selects, detects load-use hazards (one-cycle bubble) and
//            drives the register-file write port from WB.
// Config   : `WB2_HOLD_EN  - when defined, WB2 stage registers exist and
//                            select 11 returns WB2 data. When undefined, WB2
//                            is absent (rd_wb2_o=0, regwen_wb2_o=0) and
//                            select 11 falls back to the register-file data.
// Ports    : clk, reset_n (sync, active-low)
//            hold_i, flush_i                 - freeze / kill entry to MA
//            ex_rd_i, ex_regwen_i, ex_is_load_i, ex_result_i - EX instruction
//            rs1_ex_i, rs2_ex_i, rs1_use_i, rs2_use_i      - EX sources
//            rs1_rf_i, rs2_rf_i              - register-file read data
//            load_data_i                     - memory read data for MA load
//            hazard_sel_a_i, hazard_sel_b_i  - 00 rf, 01 MA, 10 WB, 11 WB2
//            rd_*_o, regwen_*_o              - per-stage tags
//            alu_in_a_o, alu_in_b_o          - forwarded operands
//            wb_data_o                       - register-file write data
//            load_use_stall_o                - hold PC/IF/ID/EX this cycle
// Revision : 1.0 - initial release
// ============================================================================
module fwd_writeback_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwen_i,
  input  logic              ex_is_load_i,
  input  logic [XLEN-1:0]   ex_result_i,
  input  logic [REG_AW-1:0] rs1_ex_i,
  input  logic [REG_AW-1:0] rs2_ex_i,
  input  logic              rs1_use_i,
  input  logic              rs2_use_i,
  input  logic [XLEN-1:0]   rs1_rf_i,
  input  logic [XLEN-1:0]   rs2_rf_i,
  input  logic [XLEN-1:0]   load_data_i,
  input  logic [1:0]        hazard_sel_a_i,
  input  logic [1:0]        hazard_sel_b_i,
  output logic [REG_AW-1:0] rd_ma_o,
  output logic [REG_AW-1:0] rd_wb_o,
  output logic [REG_AW-1:0] rd_wb2_o,
  output logic              regwen_ma_o,
  output logic              regwen_wb_o,
  output logic              regwen_wb2_o,
  output logic [XLEN-1:0]   alu_in_a_o,
  output logic [XLEN-1:0]   alu_in_b_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              load_use_stall_o
);

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_MA   = 2'b01;
  localparam logic [1:0] SEL_WB   = 2'b10;
  localparam logic [1:0] SEL_WB2  = 2'b11;

  // MA stage
  logic [REG_AW-1:0] rd_ma_q,     rd_ma_d;
  logic              regwen_ma_q, regwen_ma_d;
  logic              is_load_ma_q, is_load_ma_d;
  logic [XLEN-1:0]   alu_ma_q,    alu_ma_d;
  // WB stage
  logic [REG_AW-1:0] rd_wb_q,     rd_wb_d;
  logic              regwen_wb_q, regwen_wb_d;
  logic [XLEN-1:0]   wb_data_q,   wb_data_d;

  // Operand returned by select 11 (WB2 data or register-file fallback)
  logic [XLEN-1:0]   w_sel11_a;
  logic [XLEN-1:0]   w_sel11_b;

  logic w_hit_rs1;
  logic w_hit_rs2;

  // Load-use hazard: the load result is only available after MA, so an EX
  // consumer of the load's rd must wait one cycle. rd==0 never has regwen set,
  // so x0 can never trigger a stall. Forced low while reset is asserted.
  assign w_hit_rs1        = rs1_use_i & (rd_ma_q == rs1_ex_i);
  assign w_hit_rs2        = rs2_use_i & (rd_ma_q == rs2_ex_i);
  assign load_use_stall_o = reset_n & regwen_ma_q & is_load_ma_q & (w_hit_rs1 | w_hit_rs2);

  // Next-state for MA and WB
  always_comb begin
    rd_ma_d      = rd_ma_q;
    regwen_ma_d  = regwen_ma_q;
    is_load_ma_d = is_load_ma_q;
    alu_ma_d     = alu_ma_q;
    rd_wb_d      = rd_wb_q;
    regwen_wb_d  = regwen_wb_q;
    wb_data_d    = wb_data_q;

    if (!hold_i) begin
      if (load_use_stall_o || flush_i) begin
        rd_ma_d      = '0;
        regwen_ma_d  = 1'b0;
        is_load_ma_d = 1'b0;
        alu_ma_d     = '0;
      end else begin
        rd_ma_d      = ex_rd_i;
        regwen_ma_d  = ex_regwen_i & (ex_rd_i != '0);
        is_load_ma_d = ex_is_load_i;
        alu_ma_d     = ex_result_i;
      end
      // WB always advances, even while MA takes a bubble
      rd_wb_d     = rd_ma_q;
      regwen_wb_d = regwen_ma_q;
      wb_data_d   = is_load_ma_q ? load_data_i : alu_ma_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ma_q      <= '0;
      regwen_ma_q  <= 1'b0;
      is_load_ma_q <= 1'b0;
      alu_ma_q     <= '0;
      rd_wb_q      <= '0;
      regwen_wb_q  <= 1'b0;
      wb_data_q    <= '0;
    end else begin
      rd_ma_q      <= rd_ma_d;
      regwen_ma_q  <= regwen_ma_d;
      is_load_ma_q <= is_load_ma_d;
      alu_ma_q     <= alu_ma_d;
      rd_wb_q      <= rd_wb_d;
      regwen_wb_q  <= regwen_wb_d;
      wb_data_q    <= wb_data_d;
    end
  end

`ifdef WB2_HOLD_EN
  // WB2 keeps the value just written to the register file for one more cycle,
  // covering a register file that cannot bypass a same-cycle write to a read.
  logic [REG_AW-1:0] rd_wb2_q,     rd_wb2_d;
  logic              regwen_wb2_q, regwen_wb2_d;
  logic [XLEN-1:0]   wb2_data_q,   wb2_data_d;

  always_comb begin
    rd_wb2_d     = rd_wb2_q;
    regwen_wb2_d = regwen_wb2_q;
    wb2_data_d   = wb2_data_q;
    if (!hold_i) begin
      rd_wb2_d     = rd_wb_q;
      regwen_wb2_d = regwen_wb_q;
      wb2_data_d   = wb_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_wb2_q     <= '0;
      regwen_wb2_q <= 1'b0;
      wb2_data_q   <= '0;
    end else begin
      rd_wb2_q     <= rd_wb2_d;
      regwen_wb2_q <= regwen_wb2_d;
      wb2_data_q   <= wb2_data_d;
    end
  end

  assign rd_wb2_o     = rd_wb2_q;
  assign regwen_wb2_o = regwen_wb2_q;
  assign w_sel11_a    = wb2_data_q;
  assign w_sel11_b    = wb2_data_q;
`else
  assign rd_wb2_o     = '0;
  assign regwen_wb2_o = 1'b0;
  assign w_sel11_a    = rs1_rf_i;
  assign w_sel11_b    = rs2_rf_i;
`endif

  // Forwarding muxes, zero latency
  always_comb begin
    alu_in_a_o = rs1_rf_i;
    case (hazard_sel_a_i)
      SEL_RF:  alu_in_a_o = rs1_rf_i;
      SEL_MA:  alu_in_a_o = alu_ma_q;
      SEL_WB:  alu_in_a_o = wb_data_q;
      SEL_WB2: alu_in_a_o = w_sel11_a;
      default: alu_in_a_o = rs1_rf_i;
    endcase
  end

  always_comb begin
    alu_in_b_o = rs2_rf_i;
    case (hazard_sel_b_i)
      SEL_RF:  alu_in_b_o = rs2_rf_i;
      SEL_MA:  alu_in_b_o = alu_ma_q;
      SEL_WB:  alu_in_b_o = wb_data_q;
      SEL_WB2: alu_in_b_o = w_sel11_b;
      default: alu_in_b_o = rs2_rf_i;
    endcase
  end

  assign rd_ma_o     = rd_ma_q;
  assign regwen_ma_o = regwen_ma_q;
  assign rd_wb_o     = rd_wb_q;
  assign regwen_wb_o = regwen_wb_q;
  assign wb_data_o   = wb_data_q;

endmodule
`default_nettype wire
